// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared types and constants for the MIPS fetch stage
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] PC_STEP   = 32'd4;
  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit_if : redirect, imem and decode handshake bundle of the fetch stage
// Rev 1.0
// ============================================================================
interface pc_fetch_unit_if;
  import mips_pkg::*;

  logic              redirect_valid;
  logic [DATA_W-1:0] redirect_pc;
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              id_ready;
  logic [DATA_W-1:0] if_pc;
  logic [DATA_W-1:0] if_pc_plus4;
  logic [DATA_W-1:0] if_instr;
  logic              misalign_err;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid,
    input  id_ready,
    output if_pc, if_pc_plus4, if_instr, misalign_err
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid,
    output id_ready,
    input  if_pc, if_pc_plus4, if_instr, misalign_err
  );

endinterface
`default_nettype wire

// File: rtl/pc_adder.sv
`default_nettype none
// ============================================================================
// pc_adder : combinational WIDTH-bit adder, wraps silently mod 2^WIDTH
// Rev 1.0
// ============================================================================
module pc_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : PC holder and single-outstanding instruction fetch FSM
// Rev 1.0
// ============================================================================
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master fetch
);

  localparam logic [DATA_W-1:0] RESET_PC_ALIGNED = {RESET_PC[DATA_W-1:2], 2'b00};

  fetch_state_t      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              started_q, started_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_pc_q, if_pc_d;
  logic [DATA_W-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              misalign_q, misalign_d;

  logic [DATA_W-1:0] pc_plus4;
  logic              imem_req;
  logic              req_fire;

  pc_adder #(.WIDTH(DATA_W)) u_pc_adder (
    .a   (pc_q),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  // started_q holds the request low for the first cycle out of reset
  assign imem_req = started_q && (state_q == REQ);
  assign req_fire = imem_req && fetch.imem_gnt;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    started_d     = 1'b1;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    if_instr_d    = if_instr_q;
    misalign_d    = 1'b0;

    if (fetch.redirect_valid) begin
      pc_d       = {fetch.redirect_pc[DATA_W-1:2], 2'b00};
      misalign_d = |fetch.redirect_pc[1:0];
      unique case (state_q)
        REQ: begin
          // the granted request targets the stale PC, so its data must die
          if (req_fire) begin
            state_d = WAIT;
            kill_d  = 1'b1;
          end
        end
        WAIT: begin
          if (fetch.imem_rvalid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        HOLD: begin
          if_valid_d = 1'b0;
          state_d    = REQ;
        end
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (req_fire) state_d = WAIT;
        end
        WAIT: begin
          if (fetch.imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = REQ;
            end else begin
              if_instr_d    = fetch.imem_rdata;
              if_pc_d       = pc_q;
              if_pc_plus4_d = pc_plus4;
              pc_d          = pc_plus4;
              if_valid_d    = 1'b1;
              state_d       = HOLD;
            end
          end
        end
        HOLD: begin
          if (fetch.id_ready) begin
            if_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC_ALIGNED;
      kill_q        <= 1'b0;
      started_q     <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      if_instr_q    <= NOP_INSTR;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      started_q     <= started_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
      misalign_q    <= misalign_d;
    end
  end

  assign fetch.imem_req     = imem_req;
  assign fetch.imem_addr    = pc_q;
  assign fetch.if_valid     = if_valid_q;
  assign fetch.if_pc        = if_pc_q;
  assign fetch.if_pc_plus4  = if_pc_plus4_q;
  assign fetch.if_instr     = if_instr_q;
  assign fetch.misalign_err = misalign_q;

endmodule
`default_nettype wire
